// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage sequencer for the shared multiplier and divider units
module muldiv_ctrl #(
  parameter int WIDTH         = 32,
  parameter bit DIV_ZERO_FAST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   src_a_i,
  input  logic [WIDTH-1:0]   src_b_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               mul_start_o,
  output logic               mul_signed_o,
  input  logic               mul_ready_i,
  input  logic [2*WIDTH-1:0] mul_result_i,
  output logic               div_start_o,
  output logic               div_signed_o,
  output logic               div_annul_o,
  input  logic               div_ready_i,
  input  logic [2*WIDTH-1:0] div_result_i,
  output logic [WIDTH-1:0]   op_a_o,
  output logic [WIDTH-1:0]   op_b_o,
  output logic               busy_stall_o,
  output logic               hilo_we_o,
  output logic [2*WIDTH-1:0] hilo_o
);
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
  state_t               state;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   res_q;
  // Sequencer: flush wins over everything, DONE holds the result until the pipeline moves
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (op_valid_i) begin
          a_q  <= src_a_i;
          b_q  <= src_b_i;
          op_q <= op_i;
          if (!op_i[1]) state <= MUL_RUN;
          else if (DIV_ZERO_FAST && src_b_i == '0) begin
            state <= DONE;
            res_q <= {src_a_i, {WIDTH{1'b1}}};
          end else state <= DIV_RUN;
        end
        MUL_RUN: if (mul_ready_i) begin
          res_q <= mul_result_i;
          state <= DONE;
        end
        DIV_RUN: if (div_ready_i) begin
          res_q <= div_result_i;
          state <= DONE;
        end
        DONE: if (!stall_i) state <= IDLE;
      endcase
    end
  end
  assign mul_start_o  = state == MUL_RUN;
  assign mul_signed_o = mul_start_o & ~op_q[0];
  assign div_start_o  = state == DIV_RUN;
  assign div_signed_o = div_start_o & ~op_q[0];
  assign div_annul_o  = div_start_o & flush_i;
  assign op_a_o       = a_q;
  assign op_b_o       = b_q;
  assign busy_stall_o = mul_start_o | div_start_o | (state == IDLE & op_valid_i & ~flush_i);
  assign hilo_we_o    = state == DONE & ~stall_i & ~flush_i;
  assign hilo_o       = res_q;
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the shared multiplier and divider units.
- Accepts one MULT/MULTU/DIV/DIVU op from EX, latches the operands and drives the unit's level-held start until ready.
- Holds the result across downstream pipeline stalls and issues exactly one HI/LO write per retired op.
- Handles flush mid-operation (annul) and divide-by-zero fast completion.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH.
- DIV_ZERO_FAST, 1, when 1 a divide with src_b==0 completes without starting the divider.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid_i  in  1  EX holds a mul/div op
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a_i  in  WIDTH  multiplicand / dividend
- src_b_i  in  WIDTH  multiplier / divisor
- stall_i  in  1  pipeline held by a later stage (EX cannot advance)
- flush_i  in  1  EX flush (exception/redirect)
- mul_start_o  out  1  multiplier start, level-held
- mul_signed_o  out  1  signed multiply
- mul_ready_i  in  1  multiplier result valid (1-cycle pulse)
- mul_result_i  in  2*WIDTH  {hi,lo}
- div_start_o  out  1  divider start, level-held
- div_signed_o  out  1  signed divide
- div_annul_o  out  1  abort divider (1-cycle pulse)
- div_ready_i  in  1  divider result valid (1-cycle pulse)
- div_result_i  in  2*WIDTH  {remainder(hi), quotient(lo)}
- op_a_o  out  WIDTH  latched operand A to both units
- op_b_o  out  WIDTH  latched operand B to both units
- busy_stall_o  out  1  stall request to the pipeline
- hilo_we_o  out  1  HI/LO write enable
- hilo_o  out  2*WIDTH  {hi,lo} write data

Behaviour:
- States:
  - IDLE, MUL_RUN, DIV_RUN, DONE.
  - Reset → IDLE.
  - Reset clears the latched operands, the op and the result register to 0.
  - All outputs are 0 in reset/IDLE-without-op.
- IDLE:
  - busy_stall_o = op_valid_i & ~flush_i (combinational).
  - On op_valid_i & ~flush_i, latch src_a/src_b/op.
  - MULT/MULTU → MUL_RUN.
  - DIV/DIVU with src_b_i!=0, or DIV_ZERO_FAST=0 → DIV_RUN.
  - DIV/DIVU with src_b_i==0 and DIV_ZERO_FAST=1 → DONE, result register = {src_a_i, all-ones}.
- MUL_RUN / DIV_RUN:
  - The matching start_o is 1 and the signed_o = ~op[0] (from the latch).
  - busy_stall_o = 1.
  - op_a_o/op_b_o are stable from the latch.
  - On the matching ready_i, capture the result → DONE.
  - Ready from the non-selected unit is ignored.
- DONE:
  - busy_stall_o = 0, start outputs 0.
  - hilo_o = result register.
  - hilo_we_o = ~stall_i & ~flush_i.
  - If stall_i, stay in DONE: hold the result, no re-issue, no write.
  - Else → IDLE.
  - Exactly one hilo_we_o pulse per completed op.
- Latency:
  - Op seen in IDLE at cycle T; start high from T+1.
  - Ready at cycle R → hilo_we_o at R+1 (absent stall).
  - busy_stall_o is high T..R.
  - Divide-by-zero fast path: hilo_we_o at T+1.
- Flush (any state, highest priority):
  - Next state IDLE.
  - hilo_we_o = 0 in the flush cycle.
  - If in DIV_RUN, div_annul_o = 1 for that cycle.
  - Start outputs drop the following cycle.
  - A ready arriving in the flush cycle is discarded.
  - An op_valid in the flush cycle is not accepted.
- stall_i during RUN has no effect; the unit keeps running.
- op_valid_i in DONE is ignored: the same instruction is still in EX and must not restart.
- A new op is accepted only in IDLE, one cycle after DONE exits. Back-to-back ops therefore have ≥1 idle cycle of busy_stall_o (combinational) before the start goes high.
- hilo_o is a don't-care when hilo_we_o=0, but holds the last result (no X).

Test Plan:
- MULT a=0xFFFFFFFE(-2), b=3, unit ready 4 cycles after start → one hilo_we_o with hilo_o=0xFFFFFFFF_FFFFFFFA; busy_stall_o high exactly T..R; mul_signed_o=1.
- DIVU a=100, b=7 with stall_i high for 3 cycles after ready → state held in DONE, hilo_we_o=0 while stalled, then a single pulse with hilo_o={2,14}; div_start_o never re-asserts.
- DIV a=5, b=0, DIV_ZERO_FAST=1 → div_start_o never asserted, hilo_we_o at T+1 with hilo_o={5,0xFFFFFFFF}.
- DIV in progress, flush_i asserted 2 cycles after start → div_annul_o pulses once, IDLE next cycle, no hilo_we_o even if div_ready_i arrives in the flush cycle.
- flush_i coincident with op_valid_i in IDLE → no start, busy_stall_o=0, remains IDLE.
- MULTU 0xFFFFFFFF×0xFFFFFFFF then DIV -7/2 back-to-back → hilo writes 0xFFFFFFFE_00000001 then {0xFFFFFFFF,0xFFFFFFFD}; spurious mul_ready_i during DIV_RUN is ignored; rst asserted mid-DIV_RUN → all outputs 0 next cycle.
